serial_comp_ctrl: RTL and testbench

SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

---
 rtl/serial_comp_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_comp_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comp_ctrl.sv
// rtl/serial_comp_ctrl.sv - serial 32-bit magnitude comparator, 2 bits per cycle, MSB first
//
// Purpose:
//   Compares two 32-bit operands, unsigned or two's-complement, using one
//   2-bit compare slice that is reused every cycle. The slice walks the
//   operands from the most significant pair down to the least significant
//   pair. It stops at the first pair that differs.
//
// Ports:
//   i_clk          system clock, rising edge active
//   i_reset        synchronous active-high reset
//   i_start        compare request, sampled only in IDLE
//   i_signed_mode  1 = two's-complement compare, 0 = unsigned (sampled with start)
//   i_a, i_b       32-bit operands (sampled with start)
//   o_busy         high while a compare is in RUN or DONE
//   o_done         one-cycle pulse; o_eq/o_gt/o_lt are valid that cycle
//   o_eq, o_gt, o_lt  registered result, held until the next accepted start

module serial_comp_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_signed_mode,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_eq,
  output logic        o_gt,
  output logic        o_lt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_k;
  logic        r_ceq;
  logic        r_cgt;
  logic        r_busy;
  logic        r_done;
  logic        r_eq;
  logic        r_gt;
  logic        r_lt;

  logic [1:0]  w_pair_a;
  logic [1:0]  w_pair_b;
  logic        w_pair_gt;
  logic        w_pair_lt;
  logic        w_last;
  logic        w_ceq_nxt;
  logic        w_cgt_nxt;

  // The current pair of bits, selected by the pair index.
  assign w_pair_a  = r_a[{r_k, 1'b0} +: 2];
  assign w_pair_b  = r_b[{r_k, 1'b0} +: 2];
  assign w_pair_gt = (w_pair_a > w_pair_b);
  assign w_pair_lt = (w_pair_a < w_pair_b);

  // The compare is decided at the first differing pair. Once that pair
  // is reached, the lower pairs cannot change the outcome.
  assign w_last = (w_pair_a != w_pair_b) || (r_k == 4'd0);

  // Chain slice: the first differing pair decides the result. Later pairs
  // only hold the chain, because chain EQ has already dropped.
  always_comb begin
    w_ceq_nxt = r_ceq;
    w_cgt_nxt = r_cgt;
    if (r_ceq && w_pair_gt) begin
      w_ceq_nxt = 1'b0;
      w_cgt_nxt = 1'b1;
    end else if (r_ceq && w_pair_lt) begin
      w_ceq_nxt = 1'b0;
      w_cgt_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_k     <= 4'd0;
      r_ceq   <= 1'b0;
      r_cgt   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            // Flipping the sign bit of both operands maps two's-complement
            // order onto unsigned order. After this, the unsigned chain gives
            // the signed result, so signed_mode is not needed past capture.
            r_a     <= {i_a[31] ^ i_signed_mode, i_a[30:0]};
            r_b     <= {i_b[31] ^ i_signed_mode, i_b[30:0]};
            r_k     <= 4'd15;
            r_ceq   <= 1'b1;
            r_cgt   <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_ceq <= w_ceq_nxt;
          r_cgt <= w_cgt_nxt;
          if (w_last) begin
            r_eq    <= w_ceq_nxt;
            r_gt    <= w_cgt_nxt;
            r_lt    <= ~w_ceq_nxt & ~w_cgt_nxt;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k - 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_eq   = r_eq;
  assign o_gt   = r_gt;
  assign o_lt   = r_lt;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// tb/tb_serial_comp_ctrl.sv - self-checking bench for serial_comp_ctrl with a reference model

module tb_serial_comp_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        smode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        eq;
  logic        gt;
  logic        lt;

  int checks = 0;
  int errors = 0;

  serial_comp_ctrl dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_signed_mode (smode),
    .i_a           (a),
    .i_b           (b),
    .o_busy        (busy),
    .o_done        (done),
    .o_eq          (eq),
    .o_gt          (gt),
    .o_lt          (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the run length comes from the highest differing bit pair
  // of a^b. The sign-bit flip does not change a^b. The result comes
  // straight from the language's signed or unsigned comparison.
  function automatic int model_n(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x ^ y;
    if (d == 32'd0) return 16;
    for (int p = 15; p >= 0; p--)
      if (d[2*p +: 2] != 2'b00) return 16 - p;
    return 16;
  endfunction

  function automatic logic [2:0] model_res(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic g;
    logic l;
    if (s) begin
      g = ($signed(x) > $signed(y));
      l = ($signed(x) < $signed(y));
    end else begin
      g = (x > y);
      l = (x < y);
    end
    return {(x == y), g, l};
  endfunction

  // Stimulus and observation only: drive one compare, record what happened.
  task automatic run_cmp(input logic [31:0] xa, input logic [31:0] xb, input logic s,
                         input bit hold, input bit toggle,
                         output int done_cyc, output int done_cnt, output int busy_bad,
                         output logic [2:0] res);
    @(negedge clk);
    a = xa; b = xb; smode = s; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    done_cyc = -1; done_cnt = 0; busy_bad = 0; res = 3'bxxx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (toggle) begin
        a = $urandom; b = $urandom; smode = ~smode;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res = {eq, gt, lt};
        end
        start = 1'b0;
      end
      if (done_cyc < 0 || c == done_cyc) begin
        if (busy !== 1'b1) busy_bad++;
      end else begin
        if (busy !== 1'b0) busy_bad++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; smode = 1'b0; a = 32'h1; b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, done, eq, gt, lt});
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy got %b want 0", busy);
    end
  endtask

  task automatic check_cmp(input string name, input logic [31:0] xa, input logic [31:0] xb,
                           input logic s, input bit hold, input bit toggle);
    int dc, cnt, bb;
    logic [2:0] r, er;
    int en;
    run_cmp(xa, xb, s, hold, toggle, dc, cnt, bb, r);
    en = model_n(xa, xb);
    er = model_res(xa, xb, s);
    checks++;
    if (dc != en + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d (a=%h b=%h s=%b)", name, dc, en + 1, xa, xb, s);
    end
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL %s result eq/gt/lt: got %b want %b (a=%h b=%h s=%b)", name, r, er, xa, xb, s);
    end
    checks++;
    if (cnt != 1 || bb != 0) begin
      errors++;
      $display("FAIL %s done_pulses/busy: got %0d pulses %0d busy errs want 1/0", name, cnt, bb);
    end
    checks++;
    if ({eq, gt, lt} !== er) begin
      errors++;
      $display("FAIL %s result_hold: got %b want %b", name, {eq, gt, lt}, er);
    end
  endtask

  task automatic test_directed;
    check_cmp("equal_unsigned", 32'h12345678, 32'h12345678, 1'b0, 0, 0);
    check_cmp("msb_unsigned",   32'h80000000, 32'h00000000, 1'b0, 0, 0);
    check_cmp("msb_signed",     32'h80000000, 32'h00000000, 1'b1, 0, 0);
    check_cmp("lsb_diff",       32'h00000002, 32'h00000003, 1'b0, 0, 0);
    check_cmp("signed_neg",     32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 0, 0);
    check_cmp("mid_pair",       32'h00010000, 32'h00020000, 1'b0, 0, 0);
  endtask

  task automatic test_hold_toggle;
    check_cmp("hold_toggle_eq", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1, 1);
    check_cmp("hold_toggle_lt", 32'h7FFFFFFF, 32'h80000000, 1'b1, 1, 1);
    // Operands changing in IDLE without start must not disturb the held result.
    a = 32'h0; b = 32'hFFFFFFFF; smode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, eq, gt, lt} !== {1'b0, model_res(32'h7FFFFFFF, 32'h80000000, 1'b1)}) begin
      errors++;
      $display("FAIL idle_hold: got %b want 0%b", {busy, eq, gt, lt},
               model_res(32'h7FFFFFFF, 32'h80000000, 1'b1));
    end
  endtask

  task automatic test_random;
    logic [31:0] xa, xb;
    logic s;
    for (int i = 0; i < 40; i++) begin
      xa = $urandom;
      s  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: xb = $urandom;
        1: xb = xa;
        default: xb = xa ^ (32'($urandom_range(1, 3)) << (2 * $urandom_range(0, 15)));
      endcase
      check_cmp("random", xa, xb, s, 0, 0);
    end
  endtask

  task automatic test_reset_midrun;
    int saw_done;
    @(negedge clk);
    a = 32'hCAFEF00D; b = 32'hCAFEF00D; smode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_midrun: got %b want 00000", {busy, done, eq, gt, lt});
    end
    saw_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done++;
    end
    checks++;
    if (saw_done != 0) begin
      errors++;
      $display("FAIL reset_midrun_no_done: got %0d active cycles want 0", saw_done);
    end
    check_cmp("after_reset", 32'h00000005, 32'h00000004, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; smode = 1'b0; a = '0; b = '0;
    test_reset;
    test_directed;
    test_hold_toggle;
    test_random;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
